// File: rtl/regbus_arbiter_pkg.sv
// Shared types and widths for the two-master register-bus arbiter.
// Bus widths come from the project AHB defines; defaults apply when no header set them.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package regbus_arbiter_pkg;

    localparam int unsigned AW = `AHB_ADDR_WIDTH;
    localparam int unsigned DW = `AHB_DATA_WIDTH;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr1_rd0;
        logic [DW-1:0] wdata;
    } reg_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    // last = 1 means m1 was granted most recently
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/regbus_arbiter.sv
// Arbitrates two register-bus masters onto one IP register bus; one access per 3 cycles.
module regbus_arbiter
    import regbus_arbiter_pkg::*;
(
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_wr1_rd0,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_wr1_rd0,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] rdata,
    input  logic [DW-1:0] ip_read_data,
    output logic          valid_reg_access,
    output logic [AW-1:0] ip_addr,
    output logic          ip_wr1_rd0,
    output logic [DW-1:0] ip_write_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t   state;
    logic     win_id;
    logic     last;
    logic [1:0] win;
    reg_req_t sel;

    rr_arb2 u_rr_arb2 (
        .req  ({m1_req, m0_req}),
        .last (last),
        .win  (win)
    );

    // Payload of the current arbitration winner
    always_comb begin
        if (win[1]) begin
            sel = '{addr: m1_addr, wr1_rd0: m1_wr1_rd0, wdata: m1_wdata};
        end else begin
            sel = '{addr: m0_addr, wr1_rd0: m0_wr1_rd0, wdata: m0_wdata};
        end
    end

    // The IP bus registers double as the latched request for the ACCESS cycle
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state            <= IDLE;
            win_id           <= 1'b0;
            last             <= 1'b1;
            m0_gnt           <= 1'b0;
            m1_gnt           <= 1'b0;
            m0_done          <= 1'b0;
            m1_done          <= 1'b0;
            valid_reg_access <= 1'b0;
            ip_addr          <= '0;
            ip_wr1_rd0       <= 1'b0;
            ip_write_data    <= '0;
            rdata            <= '0;
        end else begin
            m0_gnt           <= 1'b0;
            m1_gnt           <= 1'b0;
            m0_done          <= 1'b0;
            m1_done          <= 1'b0;
            valid_reg_access <= 1'b0;
            ip_addr          <= '0;
            ip_wr1_rd0       <= 1'b0;
            ip_write_data    <= '0;
            case (state)
                IDLE: begin
                    if (|win) begin
                        state            <= ACCESS;
                        win_id           <= win[1];
                        last             <= win[1];
                        m0_gnt           <= win[0];
                        m1_gnt           <= win[1];
                        valid_reg_access <= 1'b1;
                        ip_addr          <= sel.addr;
                        ip_wr1_rd0       <= sel.wr1_rd0;
                        ip_write_data    <= sel.wr1_rd0 ? sel.wdata : DW'(0);
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    if (!ip_wr1_rd0) begin
                        rdata <= ip_read_data;
                    end
                    m0_done <= ~win_id;
                    m1_done <= win_id;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbus_arbiter.sv
// Scoreboard bench for regbus_arbiter: directed transactions push expected grants/dones.
module tb_regbus_arbiter;
    import regbus_arbiter_pkg::*;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic          m0_wr1_rd0 = 1'b0, m1_wr1_rd0 = 1'b0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m1_gnt, m0_done, m1_done;
    logic [DW-1:0] rdata;
    logic [DW-1:0] ip_read_data = '0;
    logic          valid_reg_access;
    logic [AW-1:0] ip_addr;
    logic          ip_wr1_rd0;
    logic [DW-1:0] ip_write_data;

    regbus_arbiter dut (
        .HCLK             (HCLK),
        .HRESETn          (HRESETn),
        .m0_req           (m0_req),
        .m0_addr          (m0_addr),
        .m0_wr1_rd0       (m0_wr1_rd0),
        .m0_wdata         (m0_wdata),
        .m0_gnt           (m0_gnt),
        .m0_done          (m0_done),
        .m1_req           (m1_req),
        .m1_addr          (m1_addr),
        .m1_wr1_rd0       (m1_wr1_rd0),
        .m1_wdata         (m1_wdata),
        .m1_gnt           (m1_gnt),
        .m1_done          (m1_done),
        .rdata            (rdata),
        .ip_read_data     (ip_read_data),
        .valid_reg_access (valid_reg_access),
        .ip_addr          (ip_addr),
        .ip_wr1_rd0       (ip_wr1_rd0),
        .ip_write_data    (ip_write_data)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int            id;
        int            cyc;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wd;
    } gnt_exp_t;

    typedef struct {
        int            id;
        int            cyc;
        logic [DW-1:0] rd;
    } done_exp_t;

    gnt_exp_t      gnt_q[$];
    done_exp_t     done_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] model_rdata = '0;

    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a gnt or done
    always @(negedge HCLK) begin
        if (mon_en) begin
            gnt_exp_t  g;
            done_exp_t d;
            check("gnt_excl", 64'(m0_gnt & m1_gnt), 64'd0);
            check("done_excl", 64'(m0_done & m1_done), 64'd0);
            check("valid_eq_gnt", 64'(valid_reg_access), 64'(m0_gnt | m1_gnt));
            if (!valid_reg_access)
                check("bus_idle_zero", 64'(|{ip_addr, ip_wr1_rd0, ip_write_data}), 64'd0);
            if (m0_gnt | m1_gnt) begin
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", 64'({m1_gnt, m0_gnt}), 64'd0);
                end else begin
                    g = gnt_q.pop_front();
                    check("gnt_id", 64'(m1_gnt), 64'(g.id));
                    check("gnt_cycle", 64'(cyc), 64'(g.cyc));
                    check("ip_addr", 64'(ip_addr), 64'(g.addr));
                    check("ip_wr1_rd0", 64'(ip_wr1_rd0), 64'(g.wr));
                    check("ip_write_data", 64'(ip_write_data), 64'(g.wd));
                end
            end
            if (m0_done | m1_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'({m1_done, m0_done}), 64'd0);
                end else begin
                    d = done_q.pop_front();
                    check("done_id", 64'(m1_done), 64'(d.id));
                    check("done_cycle", 64'(cyc), 64'(d.cyc));
                    check("rdata", 64'(rdata), 64'(d.rd));
                end
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_master(input int id, input logic [AW-1:0] a, input logic wr,
                              input logic [DW-1:0] wd, input logic req);
        if (id == 0) begin
            m0_addr = a; m0_wr1_rd0 = wr; m0_wdata = wd; m0_req = req;
        end else begin
            m1_addr = a; m1_wr1_rd0 = wr; m1_wdata = wd; m1_req = req;
        end
    endtask

    // Grant expected during cycle gcyc, done one cycle later
    task automatic expect_txn(input int id, input logic [AW-1:0] a, input logic wr,
                              input logic [DW-1:0] wd, input int gcyc);
        gnt_exp_t  g;
        done_exp_t d;
        g = '{id: id, cyc: gcyc, addr: a, wr: wr, wd: wr ? wd : DW'(0)};
        gnt_q.push_back(g);
        if (!wr) model_rdata = ip_read_data;
        d = '{id: id, cyc: gcyc + 1, rd: model_rdata};
        done_q.push_back(d);
    endtask

    // which: 0 m0_gnt, 1 m1_gnt, 2 m0_done, 3 m1_done
    task automatic wait_for(input int which, output bit ok);
        logic s;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            case (which)
                0: s = m0_gnt;
                1: s = m1_gnt;
                2: s = m0_done;
                default: s = m1_done;
            endcase
            if (s) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_timeout", 64'(ok), 64'd1);
    endtask

    task automatic single(input int id, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd);
        bit ok;
        set_master(id, a, wr, wd, 1'b1);
        expect_txn(id, a, wr, wd, cyc + 1);
        wait_for(2 + id, ok);
        set_master(id, a, wr, wd, 1'b0);
        repeat (2) tick();
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'(|{m0_gnt, m1_gnt, m0_done, m1_done, valid_reg_access,
                          ip_addr, ip_wr1_rd0, ip_write_data, rdata}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  ok;

        #3;
        check_all_zero("reset_outputs");
        tick();
        tick();
        HRESETn = 1'b1;
        mon_en  = 1'b1;

        // Tie right after reset: m0 first, then strict alternation every 3 cycles
        ip_read_data = 32'h1234_5678;
        base = cyc;
        set_master(0, 32'h020, 1'b0, 32'h0, 1'b1);
        set_master(1, 32'h0AA, 1'b1, 32'hCAFE_F00D, 1'b1);
        for (int k = 0; k < 4; k++)
            expect_txn(k % 2, (k % 2 == 0) ? 32'h020 : 32'h0AA, (k % 2 == 1),
                       32'hCAFE_F00D, base + 1 + 3 * k);
        repeat (11) tick();
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) tick();

        // m0 read and m1 write
        ip_read_data = 32'hDEAD_BEEF;
        single(0, 32'h010, 1'b0, 32'h0);
        ip_read_data = 32'h0BAD_F00D;
        single(1, 32'h148, 1'b1, 32'h55AA_00FF);

        // m0 drops req as soon as it is granted
        ip_read_data = 32'h0000_A5A5;
        set_master(0, 32'h3FC, 1'b0, 32'h0, 1'b1);
        expect_txn(0, 32'h3FC, 1'b0, 32'h0, cyc + 1);
        wait_for(0, ok);
        m0_req = 1'b0;
        wait_for(2, ok);
        repeat (4) tick();

        // Reset in the middle of an m1 write aborts it
        set_master(1, 32'h200, 1'b1, 32'h1111_2222, 1'b1);
        wait_for(1, ok);
        check("pre_reset_valid", 64'(valid_reg_access), 64'd1);
        check("pre_reset_wdata", 64'(ip_write_data), 64'h1111_2222);
        #1;
        HRESETn = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        m1_req = 1'b0;
        model_rdata = '0;
        tick();
        tick();
        HRESETn = 1'b1;
        repeat (5) tick();

        // Pointer is back at m1, so the next tie goes to m0
        ip_read_data = 32'h7777_8888;
        set_master(0, 32'h044, 1'b0, 32'h0, 1'b1);
        set_master(1, 32'h200, 1'b1, 32'h1111_2222, 1'b1);
        expect_txn(0, 32'h044, 1'b0, 32'h0, cyc + 1);
        wait_for(2, ok);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (4) tick();

        check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regbus_arbiter.md
REGBUS_ARBITER -- requirements
Module: regbus_arbiter

Interface
REQ-001 The block SHALL take widths from the shared `AHB_ADDR_WIDTH` (AW) and `AHB_DATA_WIDTH` (DW) defines; it has no parameters.
REQ-002 Port: HCLK  in  1  single clock; all flops on posedge.
REQ-003 Port: HRESETn  in  1  reset; asynchronous, active-low.
REQ-004 Ports m0_req / m1_req  in  1  access request; held high until the matching done.
REQ-005 Ports m0_addr / m1_addr  in  AW  register address.
REQ-006 Ports m0_wr1_rd0 / m1_wr1_rd0  in  1  1 = write, 0 = read.
REQ-007 Ports m0_wdata / m1_wdata  in  DW  write data.
REQ-008 Ports m0_gnt / m1_gnt  out  1  one-cycle pulse: request accepted.
REQ-009 Ports m0_done / m1_done  out  1  one-cycle pulse: access complete; rdata valid.
REQ-010 Port: rdata  out  DW  registered read data, shared by both requesters.
REQ-011 Port: ip_read_data  in  DW  combinational read data from the IP register file.
REQ-012 Ports valid_reg_access (out, 1), ip_addr (out, AW), ip_wr1_rd0 (out, 1) and ip_write_data (out, DW) SHALL form the shared IP register bus.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-014 In IDLE, if any req is high at a posedge, the block SHALL:
- go to ACCESS;
- latch the winner id, addr, wr1_rd0 and wdata;
- pulse the winner's gnt high for the ACCESS cycle.
REQ-015 Arbitration SHALL be round-robin:
- a single requester wins;
- if both request, the requester not granted last wins;
- after reset the last-granted pointer = m1, so m0 wins the first tie.
REQ-016 In ACCESS, the block SHALL:
- drive valid_reg_access = 1;
- drive ip_addr and ip_wr1_rd0 from the latched values;
- drive ip_write_data = latched wdata for a write, 0 for a read.
REQ-017 Outside ACCESS, valid_reg_access, ip_addr, ip_wr1_rd0 and ip_write_data SHALL all be 0.
REQ-018 At the posedge ending ACCESS:
- for a read, rdata SHALL capture ip_read_data;
- for a write, rdata SHALL hold its previous value;
- the state SHALL go to DONE.
REQ-019 In DONE, the winner's done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-020 Latency SHALL be fixed: req seen in IDLE at edge N -> gnt during cycle N+1 -> done during cycle N+2; maximum throughput is one access per 3 cycles.
REQ-021 A req dropped after gnt SHALL NOT abort the access; done SHALL still pulse.
REQ-022 A req arriving during ACCESS or DONE SHALL wait for IDLE; there SHALL be no pre-emption.
REQ-023 gnt and done SHALL never be high for both requesters in the same cycle.
REQ-024 The last-granted pointer SHALL update only on a grant.

Reset
REQ-025 On HRESETn low, asynchronously, the block SHALL force:
- state = IDLE;
- all gnt, done and valid_reg_access = 0;
- ip_addr, ip_wr1_rd0, ip_write_data and rdata = 0;
- last-granted pointer = m1.
REQ-026 A reset during ACCESS or DONE SHALL abort the access; no done SHALL pulse after reset release until a new request.
REQ-027 After reset release, the first request SHALL be sampled at the first posedge with HRESETn high.

Structure
REQ-028 AW and DW SHALL come from the shared AHB defines header; state encodings SHALL be local to this module.
REQ-029 Round-robin selection SHALL live in a sub-module rr_arb2:
- inputs: req[1:0], last-granted pointer;
- output: one-hot win[1:0];
- combinational only.
REQ-030 All outputs of regbus_arbiter SHALL be registered.

Verification
REQ-031 m0 read at 0x010, ip_read_data = 0xDEADBEEF -> valid_reg_access high 1 cycle, ip_addr = 0x010, ip_wr1_rd0 = 0; m0_done next cycle with rdata = 0xDEADBEEF.
REQ-032 m1 write 0x55AA00FF to 0x148 -> ip_write_data = 0x55AA00FF and ip_wr1_rd0 = 1 during ACCESS; m1_done 1 cycle later; rdata unchanged.
REQ-033 m0 and m1 request simultaneously after reset, held continuously -> grant order m0, m1, m0, m1 at 3-cycle spacing; no double gnt or done.
REQ-034 m0_req dropped the cycle after m0_gnt -> access completes and m0_done pulses once.
REQ-035 HRESETn asserted during ACCESS of an m1 write -> all outputs 0 immediately; no m1_done after release; the next tie goes to m0.
